// File: rtl/fft_out_scheduler_if.sv
// Purpose: handshake/status bundle between the FFT result scheduler and its neighbours.
// Latency: none, wires only.
// Backpressure: core_stall holds off the FFT core; sink_ready gates burst start.
interface fft_out_scheduler_if #(
    parameter int AW    = 3,
    parameter int CNT_W = 16
);
    logic             frame_done;
    logic             sink_ready;
    logic             wr_bank;
    logic             core_stall;
    logic             rd_en;
    logic             rd_bank;
    logic [AW-1:0]    rd_addr;
    logic             start_send;
    logic [AW-1:0]    dincounter;
    logic             sending;
    logic [CNT_W-1:0] frames_sent;
    logic             overflow;

    // Scheduler side.
    modport master (
        input  frame_done, sink_ready,
        output wr_bank, core_stall, rd_en, rd_bank, rd_addr, start_send,
               dincounter, sending, frames_sent, overflow
    );

    // FFT core / output unit side.
    modport slave (
        output frame_done, sink_ready,
        input  wr_bank, core_stall, rd_en, rd_bank, rd_addr, start_send,
               dincounter, sending, frames_sent, overflow
    );
endinterface

// File: rtl/fft_out_scheduler.sv
// Purpose: ping-pong result-bank scheduler driving row reads and the serial send window.
// Latency: start_send one cycle after IDLE sees a full bank; burst occupies 1+ROWS+RD_LAT+SEND_LEN cycles.
// Backpressure: waits in IDLE on sink_ready; core_stall when both banks full, late frames flag overflow.
module fft_out_scheduler #(
    parameter int ROWS     = 8,
    parameter int SEND_LEN = 64,
    parameter int RD_LAT   = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_out_scheduler_if.master bus
);
    localparam int AW = $clog2(ROWS);
    localparam int SW = $clog2(SEND_LEN);
    localparam int CW = (SW > AW) ? SW : AW;
    localparam logic [CW-1:0] LAST_ROW   = CW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'((RD_LAT > 0) ? RD_LAT - 1 : 0);
    localparam logic [CW-1:0] LAST_SEND  = CW'(SEND_LEN - 1);

    typedef enum logic [2:0] {IDLE, ARM, READ, DRAIN, SEND} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             rel_bank;
    logic [1:0]       full, full_rel, full_nxt;
    logic             accept;
    logic             wr_bank, rd_bank, overflow;
    logic [CNT_W-1:0] frames_sent;
    logic [AW-1:0]    rd_addr;
    logic [AW-1:0]    din;

    // State and phase counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Burst sequencing: one start cycle, row reads, read-latency drain, send window.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rel_bank  = 1'b0;
        case (state)
            IDLE: begin
                // sink_ready only matters here; after ARM the burst is committed.
                if (full[rd_bank] && bus.sink_ready) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                state_nxt = READ;
                cnt_nxt   = '0;
            end
            READ: begin
                if (cnt == LAST_ROW) begin
                    cnt_nxt   = '0;
                    state_nxt = (RD_LAT == 0) ? SEND : DRAIN;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DRAIN: begin
                if (cnt == LAST_DRAIN) begin
                    cnt_nxt   = '0;
                    state_nxt = SEND;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            SEND: begin
                if (cnt == LAST_SEND) begin
                    cnt_nxt   = '0;
                    rel_bank  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Bank occupancy: release is applied first so a frame finishing on the release cycle is accepted.
    always_comb begin
        full_rel = full;
        if (rel_bank) begin
            full_rel[rd_bank] = 1'b0;
        end
        accept   = bus.frame_done && !(&full_rel);
        full_nxt = full_rel;
        if (accept) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    // Bank pointers, sticky overflow and completed-burst counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full        <= 2'b00;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            overflow    <= 1'b0;
            frames_sent <= '0;
        end else begin
            full <= full_nxt;
            if (accept) begin
                wr_bank <= ~wr_bank;
            end
            if (bus.frame_done && !accept) begin
                overflow <= 1'b1;
            end
            if (rel_bank) begin
                rd_bank     <= ~rd_bank;
                frames_sent <= frames_sent + CNT_W'(1);
            end
        end
    end

    assign rd_addr = (state == READ) ? cnt[AW-1:0] : '0;

    // rd_addr is zero outside the read window, so delaying it gives a zero-filled dincounter.
    generate
        if (RD_LAT == 0) begin : g_nolat
            assign din = rd_addr;
        end else begin : g_lat
            logic [AW-1:0] pipe [RD_LAT];
            // Row-index delay line matching the result-memory read latency.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= rd_addr;
                    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign din = pipe[RD_LAT-1];
        end
    endgenerate

    assign bus.wr_bank     = wr_bank;
    assign bus.core_stall  = full[0] & full[1];
    assign bus.rd_en       = (state == READ);
    assign bus.rd_bank     = rd_bank;
    assign bus.rd_addr     = rd_addr;
    assign bus.start_send  = (state == ARM);
    assign bus.dincounter  = din;
    assign bus.sending     = (state == SEND);
    assign bus.frames_sent = frames_sent;
    assign bus.overflow    = overflow;
endmodule
